// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer for the EXE stage.
// Runs MULT/MULTU (32-step shift-add) and DIV/DIVU (restoring divide) on one
// shared 2*WIDTH-bit working register, then writes HI/LO.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     valid mul/div request (sampled in IDLE or DONE only)
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op1/op2   rs/rt operand values
//   cancel    pipeline flush; aborts an operation in flight
//   busy      high in PREP, RUN and FIX
//   stall_req pipeline hold request (combinational)
//   done      one-cycle pulse when hi/lo are updated
//   hi/lo     product high/low, or remainder/quotient
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic                 r_s1;
    logic                 r_s2;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_neg_prod;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // A new op is taken from IDLE (unless flushed) or straight out of DONE.
    assign w_accept = start && ((r_state == S_IDLE && !cancel) || r_state == S_DONE);

    // Signed ops work on magnitudes; |0x80000000| stays 0x80000000 unsigned.
    assign w_abs1 = (!op[0] && op1[WIDTH-1]) ? -op1 : op1;
    assign w_abs2 = (!op[0] && op2[WIDTH-1]) ? -op2 : op2;

    // Multiply step: the carry of the upper add lands in acc[MSB] after the shift.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide step: shifted remainder needs one extra bit for the compare.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_next = w_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                             : {r_acc[2*WIDTH-2:0], 1'b0};

    assign w_neg_prod = -r_acc;

    always_comb begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (r_op == 2'b00 && (r_s1 ^ r_s2)) begin
            w_fix_hi = w_neg_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_neg_prod[WIDTH-1:0];
        end else if (r_op == 2'b10) begin
            if (r_s1 ^ r_s2) w_fix_lo = -r_acc[WIDTH-1:0];
            if (r_s1)        w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_s1    <= op1[WIDTH-1];
                        r_s2    <= op2[WIDTH-1];
                        r_a     <= w_abs1;
                        r_b     <= w_abs2;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // {0, a} for multiply is the same layout as rem=0, quo=a.
                        r_acc   <= {{WIDTH{1'b0}}, r_a};
                        r_cnt   <= CW'(WIDTH - 1);
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_op[1] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_req = (start && !r_busy && (r_state != S_DONE)) || r_busy;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EXE stage of the 5-stage pipeline CPU.
- Accepts MULT/MULTU/DIV/DIVU from EXE, runs a 32-step shift-add multiply or a restoring divide, and writes HI/LO.
- Holds the pipeline via stall_req while it is busy.
- One shared 64-bit working datapath serves all four ops.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  EXE holds a valid mul/div instruction; sampled only in IDLE or DONE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op1  input  WIDTH  rs value (multiplicand / dividend)
- op2  input  WIDTH  rt value (multiplier / divisor)
- cancel  input  1  pipeline flush; aborts the operation in flight
- busy  output  1  high in PREP, RUN and FIX
- stall_req  output  1  start & ~busy & ~done_st, OR busy (combinational)
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  product[63:32] / remainder
- lo  output  WIDTH  product[31:0] / quotient

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- On reset: state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0; working registers=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE -> PREP when start=1. Latch op, sign1=op1[31], sign2=op2[31].
  - Signed ops (op[0]=0): latch |op1| and |op2|.
  - Unsigned ops: latch the raw values.
- PREP -> RUN after 1 cycle. Load the accumulator:
  - mul: acc={0, a}
  - div: rem=0, quo=a
  - counter=WIDTH-1
- RUN: one iteration per cycle, 32 cycles. Counter decrements; RUN -> FIX when counter==0 at the end of the cycle.
  - mul step: if acc[0], acc[63:32]+=b (33-bit carry kept); then shift right 1.
  - div step: shift {rem,quo} left 1; if rem>=b, rem-=b and quo[0]=1.
- FIX (1 cycle): sign correction for signed ops only.
  - MULT: negate 64-bit product if sign1^sign2.
  - DIV: negate quotient if sign1^sign2; negate remainder if sign1.
- FIX -> DONE: register hi/lo; done=1 for exactly this cycle.
- DONE -> IDLE next cycle. If start=1 in DONE, go directly to PREP (back-to-back ops; no idle bubble).
- Latency: start sampled at edge N -> done high during cycle N+35; hi/lo valid from that same cycle.
- hi/lo hold their last value until the next DONE. They are never changed by cancel or by an in-flight op.
- start while busy: ignored; operands are not re-latched.
- cancel in PREP/RUN/FIX: state=IDLE next cycle; no done pulse; hi/lo unchanged.
- cancel together with start in IDLE: start is ignored.
- cancel in DONE: no effect; the result is already committed.
- Divide by zero (op2==0): runs full latency; no trap.
  - DIVU: hi=op1, lo=0xFFFFFFFF.
  - DIV: natural algorithm result with FIX applied.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
- reset in any state: IDLE next cycle; hi=lo=0.
- Arithmetic: the abs of 0x80000000 is the unsigned value 0x80000000; the 33-bit add carry is shifted into acc[63].

Test Plan:
- Reset mid-RUN (cycle 10 of DIVU 100/7) -> next cycle busy=0, done never pulses, hi=lo=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at start+35, hi=0xFFFFFFFE, lo=0x00000001; stall_req high from start through the FIX cycle.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> hi=100, lo=0xFFFFFFFF.
- Back-to-back: DIVU 100/7 (hi=2, lo=14) with start held high in DONE for MULT 5*6 -> second done exactly 35 cycles after the first, hi=0, lo=30.
- cancel asserted at RUN cycle 5 of MULT, prior hi/lo=0x1234/0x5678 -> IDLE next cycle, no done, hi/lo stay 0x1234/0x5678.
- start asserted while busy with different operands -> ignored; the result matches the original operands.
